// File: rtl/glitch_trigger_ctrl.sv
// Glitch trigger controller: arm, wait for trigger, delay, then emit N glitch_en windows.
// Optional arm timeout is enabled by defining GLITCH_TIMEOUT_EN.
module glitch_trigger_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned WW = 8,
  parameter int unsigned CW = 4,
  parameter int unsigned TW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig_pulse,
  input  logic [DW-1:0] cfg_delay,
  input  logic [WW-1:0] cfg_width,
  input  logic [WW-1:0] cfg_gap,
  input  logic [CW-1:0] cfg_count,
  input  logic [TW-1:0] cfg_timeout,
  output logic          glitch_en,
  output logic          armed,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_GLITCH, S_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] delay_q, dcnt_q, dcnt_d;
  logic [WW-1:0] width_q, gap_q, wcnt_q, wcnt_d;
  logic [CW-1:0] count_q, rcnt_q, rcnt_d;
  logic          latch;
  logic          tmo_hit;
  logic          to_fire;

`ifdef GLITCH_TIMEOUT_EN
  logic [TW-1:0] tcnt_q;
  logic          tmo_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q   <= '0;
      tmo_en_q <= 1'b0;
    end else if (latch) begin
      tcnt_q   <= cfg_timeout;
      tmo_en_q <= (cfg_timeout != '0);
    end else if (state_q == S_ARMED && tcnt_q != '0) begin
      tcnt_q <= tcnt_q - TW'(1);
    end
  end

  assign tmo_hit = tmo_en_q && (tcnt_q == TW'(1));
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    latch   = 1'b0;
    to_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm && !abort) begin
          state_d = S_ARMED;
          latch   = 1'b1;
        end
      end
      S_ARMED: begin
        // a trigger on the last timeout cycle takes priority over the timeout
        if (trig_pulse) begin
          rcnt_d = count_q;
          if (delay_q == '0) begin
            state_d = S_GLITCH;
            wcnt_d  = width_q;
          end else begin
            state_d = S_DELAY;
            dcnt_d  = delay_q;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          to_fire = 1'b1;
        end
      end
      S_DELAY: begin
        if (dcnt_q == DW'(1)) begin
          state_d = S_GLITCH;
          wcnt_d  = width_q;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      S_GLITCH: begin
        if (wcnt_q == WW'(1)) begin
          if (rcnt_q > CW'(1)) begin
            state_d = S_GAP;
            wcnt_d  = gap_q;
            rcnt_d  = rcnt_q - CW'(1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      S_GAP: begin
        if (wcnt_q == WW'(1)) begin
          state_d = S_GLITCH;
          wcnt_d  = width_q;
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      to_fire = 1'b0;
    end
  end

  // outputs are registered from the next-state decode so they align with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      delay_q   <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      count_q   <= '0;
      glitch_en <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      if (latch) begin
        delay_q <= cfg_delay;
        width_q <= (cfg_width == '0) ? WW'(1) : cfg_width;
        gap_q   <= (cfg_gap   == '0) ? WW'(1) : cfg_gap;
        count_q <= (cfg_count == '0) ? CW'(1) : cfg_count;
      end
      glitch_en <= (state_d == S_GLITCH);
      armed     <= (state_d == S_ARMED);
      busy      <= (state_d == S_DELAY) || (state_d == S_GLITCH) || (state_d == S_GAP);
      done      <= (state_d == S_DONE);
      timeout   <= to_fire;
    end
  end

endmodule

// File: doc/glitch_trigger_ctrl.md
Name: glitch_trigger_ctrl

Overview:
Consumes the one-cycle trigger pulse produced by the positive-edge detector. Once armed, it times a programmable delay after the trigger, then drives one or more glitch-enable windows of programmable width and spacing. glitch_en feeds the clock-mux select stage of the glitchy-clock generator. All logic runs on one clock.

Parameters:
DW, 16, width of delay configuration and delay counter
WW, 8, width of glitch-width and gap configuration and counters
CW, 4, width of repeat-count configuration and counter
TW, 24, width of arm-timeout configuration and counter (used only with GLITCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
arm  in  1  one-cycle request: latch configuration and wait for trigger
abort  in  1  cancel any activity; return to IDLE
trig_pulse  in  1  single-cycle trigger from the edge detector
cfg_delay  in  DW  cycles from trigger to first glitch window
cfg_width  in  WW  glitch_en high cycles per window; 0 is treated as 1
cfg_gap  in  WW  low cycles between windows; 0 is treated as 1
cfg_count  in  CW  number of windows; 0 is treated as 1
cfg_timeout  in  TW  max cycles in ARMED; 0 disables the timeout
glitch_en  out  1  registered glitch window enable
armed  out  1  high while in ARMED
busy  out  1  high in DELAY, GLITCH or GAP
done  out  1  one-cycle pulse after the last window completes
timeout  out  1  one-cycle pulse on arm timeout; constant 0 without the macro

Behaviour:
- Reset: all outputs are 0 in the cycle after rst is sampled high. State is IDLE and counters clear. rst overrides abort, arm and trig_pulse. Reset mid-window drops glitch_en on the next edge.
- States: IDLE, ARMED, DELAY, GLITCH, GAP, DONE. All outputs are registered.
- IDLE: when arm=1, latch all cfg_* into internal registers and go to ARMED. cfg_* are ignored at all other times.
- ARMED: trig_pulse is sampled only here.
  - Trigger seen at edge T with delay D=0: go to GLITCH.
  - Trigger seen with D>0: go to DELAY.
- Timing contract: for a trigger at edge T, glitch_en is high on cycles T+1+D through T+D+W, with W being the effective width.
  - Window k (k from 0) starts at T+1+D+k*(W+G), with G being the effective gap.
  - G low cycles separate consecutive windows.
- GLITCH: hold glitch_en=1 for W cycles.
  - Then, if windows remain, go to GAP.
  - Otherwise go to DONE.
- GAP: hold glitch_en=0 for G cycles, then return to GLITCH.
- DONE: assert done=1 for exactly one cycle, on the cycle after the last glitch_en high cycle. Then go to IDLE.
- Counters: the delay counter is DW bits, the window and gap counters are WW bits, and the repeat counter is CW bits. Counters count down and never wrap.
  - Maximum values are honoured exactly, e.g. cfg_delay = 2^DW-1 gives that many delay cycles.
- Events outside ARMED:
  - arm while not IDLE is ignored.
  - trig_pulse outside ARMED is ignored.
  - A second trigger during DELAY, GLITCH or GAP has no effect.
- abort: in any non-IDLE state, go to IDLE on the next edge.
  - glitch_en, busy and armed go to 0.
  - done is not pulsed.
  - abort and arm in the same cycle in IDLE: abort wins and the state stays IDLE.
- Simultaneous arm and trig_pulse in IDLE: the trigger is ignored, because arming takes effect next cycle.

Optional Feature:
Macro: GLITCH_TIMEOUT_EN.
- Defined: a TW-bit counter runs while in ARMED.
  - If the latched cfg_timeout is nonzero and cfg_timeout cycles elapse without a trigger, timeout pulses for one cycle and the state returns to IDLE.
  - A trigger on the final timeout cycle wins over the timeout.
- Not defined: there is no timeout counter, cfg_timeout is unused, and timeout is tied 0. ARMED waits indefinitely.

Test Plan:
- Basic: delay=3, width=2, count=1, arm, then trigger at T=10 -> glitch_en high on cycles 14-15, done high on cycle 16, busy 0 on cycle 17.
- Multi-window: delay=0, width=1, gap=2, count=3, trigger at T=20 -> glitch_en high on 21, 24 and 27, done on 28.
- Zero-clamp: width=0, gap=0, count=0 -> behaves as width=1, count=1; a single-cycle glitch_en at T+1+D.
- Ignored events: trigger before arm -> no activity. Re-arm and a second trigger during DELAY -> timing unchanged. arm during GLITCH -> ignored.
- Abort/reset: abort on the 2nd cycle of a 5-cycle window -> glitch_en 0 on the next cycle, no done, IDLE. Repeat with rst -> same result, all outputs 0.
- Timeout (macro defined): cfg_timeout=100, no trigger -> timeout pulse 100 cycles after ARMED is entered, then IDLE. With cfg_timeout=0 -> stays ARMED for 1000 or more cycles.
